// File: rtl/exec_ctrl_pkg.sv
// Shared state encoding and constants for cpu_exec_ctrl; imported by the
// controller and by display logic that decodes the exported state.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    PAUSE      = 2'd1,
    RUN        = 2'd2,
    HALTED     = 2'd3
  } exec_state_t;

  localparam int unsigned RESET_HOLD_CYCLES = 2;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_exec_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-level filter and
// rising-edge detector producing a single-cycle pulse.
module debounce #(
  parameter int unsigned DEBOUNCE = 100000
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic pulse
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_d_r;
  logic          pulse_r;
  logic [CW-1:0] cnt_r;

  // Bring the raw button into the clk domain
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after DEBOUNCE consecutive disagreeing samples
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r   <= {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= sync2_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
    end
  end

  // One-cycle pulse on each accepted press
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      level_d_r <= 1'b0;
      pulse_r   <= 1'b0;
    end else begin
      level_d_r <= level_r;
      pulse_r   <= level_r & ~level_d_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/cpu_exec_ctrl.sv
// CPU execution controller: run/pause/step/halt sequencing via a cpu_en pulse.
// Optional feature macro BREAKPOINT_EN adds the pc/bp_addr breakpoint stop.
module cpu_exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned DIV      = 500000,
  parameter int unsigned DEBOUNCE = 100000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        halt,
`ifdef BREAKPOINT_EN
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
`endif
  output logic        cpu_en,
  output logic        cpu_clr,
  output logic [31:0] cycle_count,
  output logic [1:0]  state
);

  localparam int unsigned DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [1:0] HOLD_LAST = 2'(RESET_HOLD_CYCLES);

  exec_state_t   state_r, state_s;
  logic [DW-1:0] div_r, div_s;
  logic [1:0]    hold_r, hold_s;
  logic [31:0]   count_r, count_s;
  logic          en_s;
  logic          cpu_en_r;
  logic          cpu_clr_r;
  logic          run_p_s;
  logic          step_p_s;
  logic          bp_hit_s;

  debounce #(.DEBOUNCE(DEBOUNCE)) u_run_db (
    .clk(clk), .clr(clr), .din(btn_run), .pulse(run_p_s)
  );

  debounce #(.DEBOUNCE(DEBOUNCE)) u_step_db (
    .clk(clk), .clr(clr), .din(btn_step), .pulse(step_p_s)
  );

`ifdef BREAKPOINT_EN
  logic first_r, first_s;
  // The first tick after RUN entry skips the compare so a resume moves past the breakpoint
  assign bp_hit_s = ~first_r & (pc == bp_addr);
`else
  assign bp_hit_s = 1'b0;
`endif

  // Next-state, divider and pulse decision
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    hold_s  = hold_r;
    en_s    = 1'b0;
`ifdef BREAKPOINT_EN
    first_s = first_r;
`endif
    case (state_r)
      RESET_HOLD: begin
        if (hold_r == HOLD_LAST) begin
          state_s = PAUSE;
        end else begin
          hold_s = hold_r + 2'd1;
        end
      end
      PAUSE: begin
        if (halt) begin
          state_s = HALTED;
        end else if (run_p_s) begin
          state_s = RUN;
          div_s   = {DW{1'b0}};
`ifdef BREAKPOINT_EN
          first_s = 1'b1;
`endif
        end else if (step_p_s) begin
          en_s = 1'b1;
        end else begin
          en_s = 1'b0;
        end
      end
      RUN: begin
        if (halt) begin
          state_s = HALTED;
        end else if (run_p_s) begin
          state_s = PAUSE;
          div_s   = {DW{1'b0}};
        end else if (div_r == DIV_LAST) begin
          div_s = {DW{1'b0}};
`ifdef BREAKPOINT_EN
          first_s = 1'b0;
`endif
          if (bp_hit_s) begin
            state_s = PAUSE;
          end else begin
            en_s = 1'b1;
          end
        end else begin
          div_s = div_r + DW'(1);
        end
      end
      HALTED: begin
        if (step_p_s) begin
          state_s = RESET_HOLD;
          hold_s  = 2'd0;
        end else begin
          state_s = HALTED;
        end
      end
      default: begin
        state_s = RESET_HOLD;
        hold_s  = 2'd0;
      end
    endcase

    if (state_s == RESET_HOLD) begin
      count_s = 32'd0;
    end else if (en_s) begin
      count_s = sat_inc32(count_r);
    end else begin
      count_s = count_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r   <= RESET_HOLD;
      div_r     <= {DW{1'b0}};
      hold_r    <= 2'd0;
      count_r   <= 32'd0;
      cpu_en_r  <= 1'b0;
      cpu_clr_r <= 1'b1;
`ifdef BREAKPOINT_EN
      first_r   <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      hold_r    <= hold_s;
      count_r   <= count_s;
      cpu_en_r  <= en_s;
      cpu_clr_r <= (state_s == RESET_HOLD);
`ifdef BREAKPOINT_EN
      first_r   <= first_s;
`endif
    end
  end

  assign cpu_en      = cpu_en_r;
  assign cpu_clr     = cpu_clr_r;
  assign cycle_count = count_r;
  assign state       = state_r;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Self-checking bench for cpu_exec_ctrl: directed scenarios plus random
// buttons/halt/clr against a behavioural model (DIV=4, DEBOUNCE=3).
module tb_cpu_exec_ctrl;

  localparam int DIV      = 4;
  localparam int DEBOUNCE = 3;
  localparam int S_RH = 0, S_PAUSE = 1, S_RUN = 2, S_HALT = 3;

  logic        clk = 1'b0;
  logic        clr;
  logic        btn_run;
  logic        btn_step;
  logic        halt;
  logic        cpu_en;
  logic        cpu_clr;
  logic [31:0] cycle_count;
  logic [1:0]  state;
`ifdef BREAKPOINT_EN
  logic [31:0] pc;
  logic [31:0] bp_addr;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;
  int tick_no = 0;
  int en_seen = 0;
  int last_en_tick = -1;

  always #5 clk = ~clk;

  cpu_exec_ctrl #(.DIV(DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk),
    .clr(clr),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .halt(halt),
`ifdef BREAKPOINT_EN
    .pc(pc),
    .bp_addr(bp_addr),
`endif
    .cpu_en(cpu_en),
    .cpu_clr(cpu_clr),
    .cycle_count(cycle_count),
    .state(state)
  );

  // ---------------- behavioural reference model ----------------
  int                  m_state;
  int                  m_rh_edges;
  int                  m_t;
  logic                m_en;
  logic [31:0]         m_count;
  logic [DEBOUNCE+1:0] run_h, step_h;
  logic                run_lvl, run_rose, run_pls;
  logic                step_lvl, step_rose, step_pls;

  task automatic model_reset();
    m_state = S_RH; m_rh_edges = 0; m_t = 0; m_en = 1'b0; m_count = 32'd0;
    run_h = '0; run_lvl = 1'b0; run_rose = 1'b0; run_pls = 1'b0;
    step_h = '0; step_lvl = 1'b0; step_rose = 1'b0; step_pls = 1'b0;
  endtask

  // A level is accepted once DEBOUNCE consecutive samples (seen 2 cycles late) disagree with it
  task automatic btn_model(input logic din, inout logic [DEBOUNCE+1:0] h,
                           inout logic lvl, inout logic rose, inout logic pls);
    logic [DEBOUNCE-1:0] win;
    pls  = rose;
    h    = {h[DEBOUNCE:0], din};
    win  = h[DEBOUNCE+1:2];
    rose = 1'b0;
    if (!lvl && (&win)) begin lvl = 1'b1; rose = 1'b1; end
    else if (lvl && !(|win)) lvl = 1'b0;
  endtask

  task automatic model_step();
    logic rp, sp, bp;
    if (clr) begin model_reset(); return; end
    rp = run_pls;
    sp = step_pls;
    btn_model(btn_run, run_h, run_lvl, run_rose, run_pls);
    btn_model(btn_step, step_h, step_lvl, step_rose, step_pls);
`ifdef BREAKPOINT_EN
    bp = (pc == bp_addr);
`else
    bp = 1'b0;
`endif
    m_en = 1'b0;
    case (m_state)
      S_RH: begin
        m_rh_edges++;
        if (m_rh_edges > 2) m_state = S_PAUSE;
      end
      S_PAUSE: begin
        if (halt) m_state = S_HALT;
        else if (rp) begin m_state = S_RUN; m_t = 0; end
        else if (sp) m_en = 1'b1;
      end
      S_RUN: begin
        if (halt) m_state = S_HALT;
        else if (rp) m_state = S_PAUSE;
        else begin
          m_t++;
          if (m_t % DIV == 0) begin
            if (bp && m_t != DIV) m_state = S_PAUSE;
            else m_en = 1'b1;
          end
        end
      end
      default: begin
        if (sp) begin m_state = S_RH; m_rh_edges = 0; m_count = 32'd0; end
      end
    endcase
    if (m_en && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
  endtask

  // ---------------- checking ----------------
  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, obs, exp, tick_no);
    end
  endtask

  task automatic check_outputs();
    check_value("state", {30'd0, state}, 32'(m_state));
    check_value("cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
    check_value("cpu_clr", {31'd0, cpu_clr}, (m_state == S_RH) ? 32'd1 : 32'd0);
    check_value("cycle_count", cycle_count, m_count);
  endtask

  task automatic tick(input logic r, input logic s, input logic h);
    btn_run = r; btn_step = s; halt = h;
    @(posedge clk);
    tick_no++;
    model_step();
    #1;
    check_outputs();
    if (cpu_en === 1'b1) begin en_seen++; last_en_tick = tick_no; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input logic r, input logic s, input int n);
    for (int i = 0; i < n; i++) tick(r, s, 1'b0);
  endtask

  task automatic wait_state(input int st, input int limit, input string tag);
    int n = 0;
    while (m_state != st && n < limit) begin tick(1'b0, 1'b0, 1'b0); n++; end
    check_value(tag, {30'd0, state}, 32'(st));
  endtask

  task automatic assert_clr(input int n);
    clr = 1'b1;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    clr = 1'b0;
  endtask

  int          base_en, base_tick;
  logic [31:0] base_cnt;
  logic        rnd_run, rnd_step;
  int          rnd_run_left, rnd_step_left;

  initial begin
    clr = 1'b1; btn_run = 1'b0; btn_step = 1'b0; halt = 1'b0;
`ifdef BREAKPOINT_EN
    pc = 32'h0; bp_addr = 32'h10;
`endif
    model_reset();
    #2;
    check_outputs();

    // Reset hold
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    check_value("hold_clr1", {31'd0, cpu_clr}, 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check_value("hold_clr2", {31'd0, cpu_clr}, 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check_value("hold_exit", {30'd0, state}, 32'd1);
    check_value("hold_count", cycle_count, 32'd0);

    // Single step, then a bounced press
    base_tick = tick_no; base_en = en_seen;
    press(1'b0, 1'b1, 10);
    idle(10);
    check_value("step_pulses", 32'(en_seen - base_en), 32'd1);
    check_value("step_latency", 32'(last_en_tick - base_tick), 32'd7);
    check_value("step_count", cycle_count, 32'd1);
    base_en = en_seen;
    tick(1'b0, 1'b1, 1'b0); tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b1, 1'b0);
    idle(12);
    check_value("bounce_pulses", 32'(en_seen - base_en), 32'd0);

    // Run for 24 cycles then pause
    base_cnt = cycle_count;
    press(1'b1, 1'b0, 6);
    wait_state(S_RUN, 20, "run_entry");
    base_en = en_seen;
    idle(18);
    press(1'b1, 1'b0, 6);
    idle(10);
    check_value("run_pulses", 32'(en_seen - base_en), 32'd6);
    check_value("run_count", cycle_count - base_cnt, 32'd6);
    check_value("run_paused", {30'd0, state}, 32'd1);

    // Halt on the cycle the divider reaches its last value
    press(1'b1, 1'b0, 6);
    wait_state(S_RUN, 20, "halt_run_entry");
    idle(3);
    tick(1'b0, 1'b0, 1'b1);
    check_value("halt_no_pulse", {31'd0, cpu_en}, 32'd0);
    check_value("halt_state", {30'd0, state}, 32'd3);
    press(1'b1, 1'b0, 6);
    idle(6);
    check_value("halt_run_ignored", {30'd0, state}, 32'd3);
    press(1'b0, 1'b1, 6);
    wait_state(S_RH, 20, "halt_restart");
    check_value("restart_count", cycle_count, 32'd0);
    wait_state(S_PAUSE, 10, "restart_pause");

    // Simultaneous buttons, then async clear mid-RUN
    press(1'b1, 1'b1, 6);
    wait_state(S_RUN, 20, "both_run");
    check_value("both_no_pulse", {31'd0, cpu_en}, 32'd0);
    idle(6);
    assert_clr(2);
    check_value("clr_state", {30'd0, state}, 32'd0);
    wait_state(S_PAUSE, 10, "clr_pause");

`ifdef BREAKPOINT_EN
    // Breakpoint stop and resume past it
    pc = 32'h10; bp_addr = 32'h10;
    base_en = en_seen;
    press(1'b1, 1'b0, 6);
    wait_state(S_RUN, 20, "bp_run");
    wait_state(S_PAUSE, 20, "bp_stop");
    check_value("bp_pulses", 32'(en_seen - base_en), 32'd1);
    press(1'b1, 1'b0, 6);
    wait_state(S_RUN, 20, "bp_resume");
    idle(4);
    check_value("bp_first_tick", {31'd0, cpu_en}, 32'd1);
    press(1'b1, 1'b0, 6);
    idle(4);
    pc = 32'h0;
`endif

    // Randomized buttons, halt and occasional async clear
    rnd_run = 1'b0; rnd_step = 1'b0; rnd_run_left = 0; rnd_step_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rnd_run_left == 0) begin
        rnd_run = 1'($urandom_range(0, 1)); rnd_run_left = $urandom_range(1, 8);
      end
      if (rnd_step_left == 0) begin
        rnd_step = 1'($urandom_range(0, 1)); rnd_step_left = $urandom_range(1, 8);
      end
      rnd_run_left--;
      rnd_step_left--;
`ifdef BREAKPOINT_EN
      pc = ($urandom_range(0, 3) == 0) ? 32'h10 : $urandom;
`endif
      if ($urandom_range(0, 399) == 0) assert_clr($urandom_range(1, 3));
      else tick(rnd_run, rnd_step, ($urandom_range(0, 29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule

// File: doc/cpu_exec_ctrl.md
# cpu_exec_ctrl

Execution controller that sequences the CPU core from the board clock. It replaces the free-running divided CPU clock with a single-cycle clock-enable pulse, `cpu_en`, driven by a run/pause/step/halt state machine. It also generates the CPU clear and keeps a saturating count of executed cycles for the segment display. It sits in `top` between the raw board buttons and `cpu`.

## Interface
- `DIV`, 500000: board-clock cycles per CPU tick in RUN; legal range 2..2^24.
- `DEBOUNCE`, 100000: board-clock cycles a button input must hold a stable level before it is accepted.
- `clk` in 1: board clock; all logic on posedge.
- `clr` in 1: reset, asynchronous, active-high.
- `btn_run` in 1: raw run/pause toggle button, asynchronous, active-high.
- `btn_step` in 1: raw single-step button, asynchronous, active-high.
- `halt` in 1: CPU halt flag, synchronous to `clk`.
- `pc` in 32: CPU program counter; present only with `BREAKPOINT_EN`.
- `bp_addr` in 32: breakpoint address; present only with `BREAKPOINT_EN`.
- `cpu_en` out 1: one-`clk` pulse; the CPU advances exactly one cycle per pulse.
- `cpu_clr` out 1: clear to the CPU.
- `cycle_count` out 32: number of `cpu_en` pulses issued.
- `state` out 2: current FSM state encoding.

## Operation
- **Buttons.** Each button passes through a 2-flop synchronizer, then the debouncer, then a rising-edge detector. The result is a 1-cycle `run_p` or `step_p` pulse.
- **States.** RESET_HOLD=0, PAUSE=1, RUN=2, HALTED=3.
- **RESET_HOLD.**
  - `cpu_clr`=1 and `cpu_en`=0.
  - Stays in this state for exactly 2 `clk` cycles after `clr` falls, then goes to PAUSE.
- **PAUSE.**
  - `step_p` produces one `cpu_en` pulse on the next cycle; state stays PAUSE.
  - `run_p` goes to RUN and clears the divider.
  - If `run_p` and `step_p` arrive together, `run_p` wins and no step pulse is issued.
  - If `halt`=1, go to HALTED; no step is issued.
- **RUN.**
  - The divider counts 0..DIV-1 and wraps to 0.
  - When the divider equals DIV-1 and `halt`=0, issue one `cpu_en` pulse.
  - `run_p` goes to PAUSE and clears the divider. No pulse is issued that cycle, even if the divider is at DIV-1.
  - `halt`=1 goes to HALTED immediately and suppresses any pulse that cycle.
  - `step_p` is ignored.
- **HALTED.**
  - `cpu_en` stays 0; `run_p` is ignored.
  - `step_p` goes to RESET_HOLD, which restarts the program. `cycle_count` is cleared to 0 on entry to RESET_HOLD.
- **cycle_count.** Increments by 1 in the same cycle each `cpu_en` pulse is driven, and saturates at 0xFFFF_FFFF.
- **Async reset.** `clr` asserted at any time forces the following immediately, regardless of in-flight pulses or debounce counts:
  - state RESET_HOLD, `cpu_clr`=1, `cpu_en`=0, `cycle_count`=0;
  - divider and debounce counters to 0;
  - synchronizers and edge detectors to 0.

## Timing
- **Reset values:** `cpu_en`=0, `cpu_clr`=1, `cycle_count`=0, `state`=0.
- **Outputs:** all outputs are registered; none combinational from inputs.
- **Button latency:** from a raw press held stable to `run_p`/`step_p` is 2 (sync) + DEBOUNCE + 1 (edge) cycles.
- **Step latency:** from `step_p` to `cpu_en` is 1 cycle.
- **RUN rate:** first pulse DIV cycles after RUN entry, then one pulse every DIV cycles.
- **Pulse spacing:** `cpu_en` is never high for two consecutive cycles (guaranteed by DIV ≥ 2).

## Configuration
- **`BREAKPOINT_EN` defined:**
  - `pc` and `bp_addr` ports exist.
  - In RUN, when the divider is at DIV-1 and `pc`==`bp_addr`, no pulse is issued and the FSM goes to PAUSE.
  - The compare is skipped for the first tick after each RUN entry, so resuming from a breakpoint advances past it.
  - Steps from PAUSE ignore the breakpoint.
- **`BREAKPOINT_EN` undefined:** `pc` and `bp_addr` are absent, and no comparator or first-tick flag is built.

## Structure
- **Package `exec_ctrl_pkg`:** the `exec_state_t` enum (2-bit, encodings above) and the `RESET_HOLD_CYCLES`=2 constant. `top` and the display logic import this package to decode `state`.
- **Sub-module `debounce`:** parameter DEBOUNCE; ports `clk`, `clr`, `din`, `pulse`. It contains the synchronizer, stable counter and edge detector, and is instantiated twice.

## Test plan
Bench parameters: DIV=4, DEBOUNCE=3.
- **Reset hold:** assert `clr` for 5 cycles, then release → `cpu_clr`=1 for 2 cycles, then `state`=1, `cpu_en`=0, `cycle_count`=0.
- **Single step:** hold `btn_step` 10 cycles in PAUSE → exactly one `cpu_en` pulse 7 cycles after the press, `cycle_count`=1. Bounce the press 1-0-1 within 2 cycles → no pulse.
- **Run/pause:** press run, let 24 cycles elapse after RUN entry, then press run again → 6 pulses spaced 4 cycles apart, `cycle_count`=6, `state`=1.
- **Halt:** in RUN, raise `halt` on the cycle the divider is at 3 → no pulse that cycle, `state`=3. A subsequent run press has no effect; a step press → RESET_HOLD, then `cycle_count`=0.
- **Simultaneous buttons:** in PAUSE, `run_p` and `step_p` in the same cycle → `state`=2 and no immediate pulse. Async `clr` mid-RUN → all outputs at reset values in the same cycle.
- **Breakpoint (`BREAKPOINT_EN`):** `bp_addr`=0x10, `pc`=0x10 during RUN → PAUSE with no pulse. Pressing run again → first tick pulses despite the match.
